kamus_if_prefetch: RTL and testbench
====================================

# kamus_if_prefetch

Parametrised instruction-fetch stage with an internal prefetch queue, decoupling the L1I request/response protocol from the ID stage. It keeps a fetch PC, issues in-order word requests to L1I on a request/grant handshake, buffers returned instructions with their PCs in a FIFO, and presents them to ID on a valid/ready handshake. A redirect from EX (taken branch, jump) flushes the queue and discards in-flight responses, which the single-register IF cannot do.

## Interface
- BOOT_ADDR, 32'h0, PC of the first fetch after reset
- FIFO_DEPTH, 4, queue entries; power of two, >= 2; also the maximum number of queued plus outstanding requests
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, synchronous, active-low
- redirect_i  input  1  EX redirect (taken branch / jump); flush and restart
- redirect_addr_i  input  32  new fetch PC; bits [1:0] ignored (treated as 0)
- l1i_req_o  output  1  fetch request valid
- l1i_addr_o  output  32  fetch address, word-aligned
- l1i_gnt_i  input  1  request accepted this cycle
- l1i_rvalid_i  input  1  response valid; responses are in request order, >= 1 cycle after grant
- l1i_rdata_i  input  32  response instruction word
- instr_valid_o  output  1  queue head valid
- instr_ready_i  input  1  ID accepts head this cycle
- instr_data_o  output  32  head instruction
- instr_pc_o  output  32  head PC
- next_pc_o  output  32  instr_pc_o + 4

## Operation
- FSM states (if_state_e): BOOT_ST, RUN_ST, FLUSH_ST.
- BOOT_ST: entered on reset; l1i_req_o = 0; next cycle -> RUN_ST.
- RUN_ST: l1i_req_o = 1 when fifo_count + outstanding < FIFO_DEPTH. Grant (req & gnt): fetch_pc += 4, outstanding += 1. rvalid: push {fetch-order PC, rdata} into FIFO, outstanding -= 1. Grant and rvalid in the same cycle leave outstanding unchanged.
- Redirect (any state except BOOT_ST): FIFO cleared, fetch_pc = {redirect_addr_i[31:2], 2'b00}, discard = outstanding (+1 if grant same cycle, -1 if rvalid same cycle). discard > 0 -> FLUSH_ST, else RUN_ST.
- FLUSH_ST: l1i_req_o = 0; each rvalid dropped, discard -= 1; at discard reaching 0 -> RUN_ST. A new redirect in FLUSH_ST reloads fetch_pc, keeps current discard count.
- Credit rule guarantees no push when full; a push while full is an assertion failure.
- The PC paired with each response comes from a response-PC register that advances by 4 per accepted response and is loaded with the redirect address on redirect.
- Arithmetic: PCs modulo 2^32 (0xFFFFFFFC + 4 wraps to 0). Counters clog2(FIFO_DEPTH+1) bits.

## Timing
- Reset values: l1i_req_o 0, l1i_addr_o BOOT_ADDR, instr_valid_o 0, instr_data_o 32'h00000013 (NOP), instr_pc_o 0, next_pc_o 4, state BOOT_ST, counts 0.
- First request: cycle 2 after rst_ni rises (BOOT_ST, then RUN_ST).
- l1i_addr_o is the registered fetch_pc; held stable while l1i_req_o = 1 and no grant.
- Response-to-ID latency: rvalid in cycle N -> instr_valid_o in cycle N+1 (registered queue output, no bypass).
- Pop when instr_valid_o & instr_ready_i; simultaneous push and pop allowed at any count, including full.
- Redirect in cycle N: instr_valid_o = 0 in N+1; a pop in cycle N is still counted as accepted by ID (ID squashes it); first request to new PC in N+1 if discard = 0.
- Redirect beats grant, rvalid and pop in the same cycle.
- Reset asserted mid-operation: all state to reset values next edge; responses still in flight after reset are ignored (outstanding = 0, L1I is reset together with the core).

## Structure
- kamus_pkg: if_state_e {BOOT_ST, RUN_ST, FLUSH_ST}; NOP_INSTR = 32'h00000013.
- Sub-module kamus_sync_fifo (WIDTH, DEPTH; push/pop/flush, full/empty/count, registered head) stores {pc, instr}, 64 bits wide. Top holds FSM, fetch_pc, response-PC, outstanding and discard counters.

## Test plan
- Reset, gnt_i = 1, rvalid one cycle after grant, ready = 1 -> requests at 0x0, 0x4, 0x8...; instr_pc_o 0x0 with instr_valid_o two cycles after first grant.
- ready_i = 0, FIFO_DEPTH = 4 -> exactly 4 grants, then l1i_req_o = 0 with count 4 and outstanding 0; ready_i = 1 -> one new request per pop.
- Redirect to 0x103 with 2 outstanding -> FLUSH_ST, next two rvalids dropped, next request address 0x100, first delivered instr_pc_o 0x100.
- Redirect in the same cycle as grant and rvalid with outstanding 1 -> discard = 1, that rvalid dropped, state FLUSH_ST.
- BOOT_ADDR = 32'hFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; next_pc_o at 0xFFFFFFFC is 0x0.
- rst_ni low while queue full and 2 outstanding -> next cycle all outputs at reset values; later stray rvalid ignored.

Source files
------------

// File: rtl/kamus_pkg.sv
// kamus_pkg: shared fetch-stage state encoding and constants
package kamus_pkg;
    typedef enum logic [1:0] {BOOT_ST, RUN_ST, FLUSH_ST} if_state_e;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/kamus_if_prefetch_if.sv
// kamus_if_prefetch_if: EX redirect, L1I request/response and ID valid/ready bundle
interface kamus_if_prefetch_if;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        l1i_req_o;
    logic [31:0] l1i_addr_o;
    logic        l1i_gnt_i;
    logic        l1i_rvalid_i;
    logic [31:0] l1i_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_data_o;
    logic [31:0] instr_pc_o;
    logic [31:0] next_pc_o;
    modport master (
        input  redirect_i, redirect_addr_i, l1i_gnt_i, l1i_rvalid_i, l1i_rdata_i, instr_ready_i,
        output l1i_req_o, l1i_addr_o, instr_valid_o, instr_data_o, instr_pc_o, next_pc_o
    );
    modport slave (
        output redirect_i, redirect_addr_i, l1i_gnt_i, l1i_rvalid_i, l1i_rdata_i, instr_ready_i,
        input  l1i_req_o, l1i_addr_o, instr_valid_o, instr_data_o, instr_pc_o, next_pc_o
    );
endinterface

// File: rtl/kamus_sync_fifo.sv
// kamus_sync_fifo: synchronous FIFO with flush, occupancy count and memory-backed head
module kamus_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [WIDTH-1:0]           o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push, w_pop;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    always_ff @(posedge clk_i) begin
        if (!rst_ni || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/kamus_if_prefetch.sv
// kamus_if_prefetch: credit-limited L1I fetch stage with a prefetch queue toward ID
module kamus_if_prefetch import kamus_pkg::*; #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    kamus_if_prefetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    if_state_e    r_state, w_state_nxt;
    logic [31:0]  r_fetch_pc, r_resp_pc, w_fetch_nxt, w_resp_nxt, w_redir_pc;
    logic [CW-1:0] r_outstanding, r_discard, w_out_nxt, w_discard_nxt, w_count;
    logic         w_req, w_gnt, w_rsp, w_drop, w_redir, w_push, w_pop, w_full, w_empty;
    logic [63:0]  w_head;
    assign w_redir    = bus.redirect_i && r_state != BOOT_ST;
    assign w_redir_pc = {bus.redirect_addr_i[31:2], 2'b00};
    assign w_req      = r_state == RUN_ST && ({1'b0, w_count} + {1'b0, r_outstanding} < (CW+1)'(FIFO_DEPTH));
    assign w_gnt      = w_req & bus.l1i_gnt_i;
    // responses with nothing outstanding (e.g. stray after reset) are ignored
    assign w_rsp      = bus.l1i_rvalid_i && r_state == RUN_ST && r_outstanding != '0;
    assign w_drop     = bus.l1i_rvalid_i && r_state == FLUSH_ST && r_discard != '0;
    assign w_push     = w_rsp & ~w_redir;
    assign w_pop      = ~w_empty & bus.instr_ready_i;
    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_nxt   = w_gnt ? r_fetch_pc + 32'd4 : r_fetch_pc;
        w_resp_nxt    = w_rsp ? r_resp_pc + 32'd4 : r_resp_pc;
        w_out_nxt     = r_outstanding + CW'(w_gnt) - CW'(w_rsp);
        w_discard_nxt = r_discard - CW'(w_drop);
        if (r_state == BOOT_ST || (r_state == FLUSH_ST && w_discard_nxt == '0)) w_state_nxt = RUN_ST;
        if (w_redir) begin
            // everything still in flight, including a same-cycle grant, must be dropped
            w_discard_nxt = w_discard_nxt + w_out_nxt;
            w_out_nxt     = '0;
            w_fetch_nxt   = w_redir_pc;
            w_resp_nxt    = w_redir_pc;
            w_state_nxt   = w_discard_nxt != '0 ? FLUSH_ST : RUN_ST;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= BOOT_ST;
            r_fetch_pc    <= BOOT_ADDR;
            r_resp_pc     <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_nxt;
            r_resp_pc     <= w_resp_nxt;
            r_outstanding <= w_out_nxt;
            r_discard     <= w_discard_nxt;
        end
    end
    kamus_sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_data  ({r_resp_pc, bus.l1i_rdata_i}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );
    assign bus.l1i_req_o     = w_req;
    assign bus.l1i_addr_o    = r_fetch_pc;
    assign bus.instr_valid_o = ~w_empty;
    assign {bus.instr_pc_o, bus.instr_data_o} = w_empty ? {32'h0, NOP_INSTR} : w_head;
    assign bus.next_pc_o     = bus.instr_pc_o + 32'd4;
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_kamus_if_prefetch.sv
// tb_kamus_if_prefetch: directed stimulus with an in-order scoreboard on the ID side
module tb_kamus_if_prefetch;
    import kamus_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    kamus_if_prefetch_if b0();
    kamus_if_prefetch_if b1();
    kamus_if_prefetch #(.BOOT_ADDR(32'h0), .FIFO_DEPTH(4)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0.master));
    kamus_if_prefetch #(.BOOT_ADDR(32'hFFFFFFF8), .FIFO_DEPTH(4)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.master));
    int n_chk = 0;
    int n_fail = 0;
    int grants = 0;
    int pops = 0;
    bit auto_en = 1'b1;
    bit gnt_en = 1'b0;
    bit rsp_en = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] pend[$];
    logic [31:0] pend1[$];
    logic [31:0] addr1_q[$];
    logic [95:0] pop1_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_exp(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({base + 32'(i * 4), ~(base + 32'(i * 4))});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(b0.l1i_req_o), 32'd0);
        check({tag, "_addr"}, b0.l1i_addr_o, 32'h0);
        check({tag, "_valid"}, 32'(b0.instr_valid_o), 32'd0);
        check({tag, "_data"}, b0.instr_data_o, 32'h00000013);
        check({tag, "_pc"}, b0.instr_pc_o, 32'h0);
        check({tag, "_next_pc"}, b0.next_pc_o, 32'h4);
        check({tag, "_state"}, 32'(dut0.r_state), 32'(BOOT_ST));
        check({tag, "_outstanding"}, 32'(dut0.r_outstanding), 32'd0);
    endtask

    // scoreboard monitor: every accepted head must match the next expected {pc, instr}
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && b0.instr_valid_o && b0.instr_ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h, no entry expected", b0.instr_pc_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", b0.instr_pc_o, e[63:32]);
                check("sb_data", b0.instr_data_o, e[31:0]);
                check("sb_next_pc", b0.next_pc_o, e[63:32] + 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b1.instr_valid_o) pop1_q.push_back({b1.instr_pc_o, b1.instr_data_o, b1.next_pc_o});
    end

    // L1I model for dut0: in-order, response one cycle after grant, data = ~addr
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            pend.delete();
            b0.l1i_gnt_i    = 1'b0;
            b0.l1i_rvalid_i = 1'b0;
        end else if (auto_en) begin
            if (rsp_en && pend.size() > 0) begin
                b0.l1i_rvalid_i = 1'b1;
                b0.l1i_rdata_i  = ~pend.pop_front();
            end else b0.l1i_rvalid_i = 1'b0;
            b0.l1i_gnt_i = gnt_en;
            if (gnt_en && b0.l1i_req_o) begin
                pend.push_back(b0.l1i_addr_o);
                grants++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            pend1.delete();
            b1.l1i_rvalid_i = 1'b0;
        end else begin
            if (pend1.size() > 0) begin
                b1.l1i_rvalid_i = 1'b1;
                b1.l1i_rdata_i  = ~pend1.pop_front();
            end else b1.l1i_rvalid_i = 1'b0;
            if (b1.l1i_req_o) begin
                pend1.push_back(b1.l1i_addr_o);
                addr1_q.push_back(b1.l1i_addr_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.redirect_i = 1'b0;
        b0.redirect_addr_i = 32'h0;
        b0.l1i_gnt_i = 1'b0;
        b0.l1i_rvalid_i = 1'b0;
        b0.l1i_rdata_i = 32'h0;
        b0.instr_ready_i = 1'b0;
        b1.redirect_i = 1'b0;
        b1.redirect_addr_i = 32'h0;
        b1.l1i_gnt_i = 1'b1;
        b1.l1i_rvalid_i = 1'b0;
        b1.l1i_rdata_i = 32'h0;
        b1.instr_ready_i = 1'b1;
        step(3);
        check_reset_outputs("rst");
        // streaming with grant always, one-cycle responses, ID always ready
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        b0.instr_ready_i = 1'b1;
        fill_exp(32'h0, 16);
        rst_n = 1'b1;
        check("boot_req", 32'(b0.l1i_req_o), 32'd0);
        step();
        check("req1", 32'(b0.l1i_req_o), 32'd1);
        check("addr1", b0.l1i_addr_o, 32'h0);
        step();
        check("addr2", b0.l1i_addr_o, 32'h4);
        step();
        check("addr3", b0.l1i_addr_o, 32'h8);
        check("first_valid", 32'(b0.instr_valid_o), 32'd1);
        check("first_pc", b0.instr_pc_o, 32'h0);
        step(5);
        // back-pressure: four credits, then one request per pop
        b0.instr_ready_i = 1'b0;
        rst_n = 1'b0;
        step(3);
        fill_exp(32'h0, 8);
        grants = 0;
        pops = 0;
        rst_n = 1'b1;
        step(10);
        check("bp_grants", 32'(grants), 32'd4);
        check("bp_req", 32'(b0.l1i_req_o), 32'd0);
        check("bp_count", 32'(dut0.w_count), 32'd4);
        check("bp_outstanding", 32'(dut0.r_outstanding), 32'd0);
        b0.instr_ready_i = 1'b1;
        step();
        b0.instr_ready_i = 1'b0;
        step(6);
        check("bp_pops", 32'(pops), 32'd1);
        check("bp_grants_after_pop", 32'(grants), 32'd5);
        check("bp_req_after_pop", 32'(b0.l1i_req_o), 32'd0);
        check("bp_head_pc", b0.instr_pc_o, 32'h4);
        // redirect with two responses outstanding
        rst_n = 1'b0;
        step(3);
        exp_q.delete();
        gnt_en = 1'b1;
        rsp_en = 1'b0;
        b0.instr_ready_i = 1'b1;
        rst_n = 1'b1;
        step(3);
        gnt_en = 1'b0;
        check("rd_outstanding", 32'(dut0.r_outstanding), 32'd2);
        fill_exp(32'h100, 4);
        b0.redirect_i = 1'b1;
        b0.redirect_addr_i = 32'h103;
        step();
        b0.redirect_i = 1'b0;
        check("rd_state_flush", 32'(dut0.r_state), 32'(FLUSH_ST));
        check("rd_discard", 32'(dut0.r_discard), 32'd2);
        check("rd_flush_req", 32'(b0.l1i_req_o), 32'd0);
        rsp_en = 1'b1;
        gnt_en = 1'b1;
        step();
        check("rd_still_flush", 32'(dut0.r_state), 32'(FLUSH_ST));
        step();
        check("rd_run", 32'(dut0.r_state), 32'(RUN_ST));
        check("rd_req", 32'(b0.l1i_req_o), 32'd1);
        check("rd_addr", b0.l1i_addr_o, 32'h100);
        step(2);
        check("rd_valid", 32'(b0.instr_valid_o), 32'd1);
        check("rd_pc", b0.instr_pc_o, 32'h100);
        // redirect coinciding with grant and response, one outstanding
        step();
        check("rg_outstanding", 32'(dut0.r_outstanding), 32'd1);
        check("rg_req", 32'(b0.l1i_req_o), 32'd1);
        b0.redirect_i = 1'b1;
        b0.redirect_addr_i = 32'h200;
        step();
        b0.redirect_i = 1'b0;
        fill_exp(32'h200, 4);
        check("rg_state_flush", 32'(dut0.r_state), 32'(FLUSH_ST));
        check("rg_discard", 32'(dut0.r_discard), 32'd1);
        check("rg_valid_cleared", 32'(b0.instr_valid_o), 32'd0);
        step();
        check("rg_run", 32'(dut0.r_state), 32'(RUN_ST));
        check("rg_addr", b0.l1i_addr_o, 32'h200);
        check("rg_dropped", 32'(b0.instr_valid_o), 32'd0);
        step(2);
        check("rg_valid", 32'(b0.instr_valid_o), 32'd1);
        check("rg_pc", b0.instr_pc_o, 32'h200);
        // reset with the credit window full, then a stray response
        step(3);
        b0.instr_ready_i = 1'b0;
        rsp_en = 1'b0;
        step(6);
        check("mr_req_stalled", 32'(b0.l1i_req_o), 32'd0);
        rst_n = 1'b0;
        step();
        check_reset_outputs("mr");
        exp_q.delete();
        auto_en = 1'b0;
        step();
        b0.l1i_gnt_i = 1'b0;
        b0.instr_ready_i = 1'b1;
        rst_n = 1'b1;
        step();
        b0.l1i_rvalid_i = 1'b1;
        b0.l1i_rdata_i = 32'hDEADBEEF;
        step();
        b0.l1i_rvalid_i = 1'b0;
        check("stray_valid", 32'(b0.instr_valid_o), 32'd0);
        check("stray_outstanding", 32'(dut0.r_outstanding), 32'd0);
        step();
        check("stray_valid2", 32'(b0.instr_valid_o), 32'd0);
        // wrap-around fetch from BOOT_ADDR 0xFFFFFFF8 (first run after the initial reset)
        check("wrap_nreq", 32'(addr1_q.size() >= 3), 32'd1);
        if (addr1_q.size() >= 3) begin
            check("wrap_addr0", addr1_q[0], 32'hFFFFFFF8);
            check("wrap_addr1", addr1_q[1], 32'hFFFFFFFC);
            check("wrap_addr2", addr1_q[2], 32'h0);
        end
        check("wrap_npop", 32'(pop1_q.size() >= 2), 32'd1);
        if (pop1_q.size() >= 2) begin
            check("wrap_pc0", pop1_q[0][95:64], 32'hFFFFFFF8);
            check("wrap_data0", pop1_q[0][63:32], 32'h00000007);
            check("wrap_next0", pop1_q[0][31:0], 32'hFFFFFFFC);
            check("wrap_pc1", pop1_q[1][95:64], 32'hFFFFFFFC);
            check("wrap_next1", pop1_q[1][31:0], 32'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
